// File: rtl/ram_lsu_if.sv
// Core-side request/response channel plus the word-organised RAM port of the LSU.
// "slave" is the LSU's view; "master" is the core/RAM side that drives requests and read data.
interface ram_lsu_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic                  rsp_valid;
   logic [31:0]           rsp_rdata;
   logic                  rsp_err;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wr_data;
   logic                  mem_wr_en;
   logic [31:0]           mem_rd_data;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd_data,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wr_data, mem_wr_en
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd_data,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wr_data, mem_wr_en
   );
endinterface

// File: rtl/ram_lsu.sv
// Load/store unit for a word RAM with combinational read: byte/half/word access,
// read-modify-write for sub-word stores, sign/zero extension on loads, alignment checks.
module ram_lsu #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   ram_lsu_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_e;

   state_e                state_q, state_d;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic                  err_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wrw_q, wrw_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  accept;
   logic                  req_err;

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] a, input logic u);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   extract = {{24{~u & b[7]}}, b};
         2'b01:   extract = {{16{~u & h[15]}}, h};
         default: extract = w;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                         input logic [1:0] sz, input logic [1:0] a);
      merge = w;
      if (sz == 2'b00)  merge[{a, 3'b000} +: 8] = d[7:0];
      else if (a[1])    merge[31:16] = d[15:0];
      else              merge[15:0]  = d[15:0];
   endfunction

   assign accept  = bus.req_valid && (state_q == IDLE);
   assign req_err = (bus.req_size == 2'b11) ||
                    (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                    (bus.req_size == 2'b10 && (bus.req_addr[1:0] != 2'b00));

   // wrw_q first holds the raw store data, then becomes the merged word written to RAM.
   always_comb begin
      state_d = state_q;
      wrw_d   = wrw_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (accept) begin
            rdata_d = '0;
            wrw_d   = bus.req_wdata;
            if (req_err)                  state_d = RESP;
            else if (!bus.req_we)         state_d = LOAD;
            else if (bus.req_size == 2'b10) state_d = WRITE;
            else                          state_d = RMW_RD;
         end
         LOAD: begin
            rdata_d = extract(bus.mem_rd_data, size_q, addr_q[1:0], uns_q);
            state_d = RESP;
         end
         RMW_RD: begin
            wrw_d   = merge(bus.mem_rd_data, wrw_q, size_q, addr_q[1:0]);
            state_d = WRITE;
         end
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         size_q  <= '0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wrw_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wrw_q   <= wrw_d;
         rdata_q <= rdata_d;
         if (accept) begin
            size_q <= bus.req_size;
            uns_q  <= bus.req_unsigned;
            err_q  <= req_err;
            addr_q <= bus.req_addr;
         end
      end
   end

   assign bus.req_ready   = (state_q == IDLE);
   assign bus.rsp_valid   = (state_q == RESP);
   assign bus.rsp_err     = (state_q == RESP) && err_q;
   assign bus.rsp_rdata   = rdata_q;
   assign bus.mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign bus.mem_wr_data = wrw_q;
   assign bus.mem_wr_en   = (state_q == WRITE);
endmodule

// File: tb/tb_ram_lsu.sv
// Scoreboard bench for ram_lsu: a reference RAM and extend/merge model predict every
// response and RAM write, including the cycle it must appear in.
module tb_ram_lsu;
   localparam int AW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic preload = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ram_lsu_if #(.ADDR_WIDTH(AW)) bus ();
   ram_lsu #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [31:0] ram     [64];
   logic [31:0] ref_mem [64];

   function automatic logic [31:0] init_val(input int i);
      if (i == 8)       return 32'h1122_3344;
      else if (i == 12) return 32'h80FF_7F01;
      else              return 32'hA500_0000 | (i * 32'h0001_0101);
   endfunction

   assign bus.mem_rd_data = ram[bus.mem_addr[7:2]];
   always @(posedge clk) begin
      if (preload) for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
      else if (bus.mem_wr_en) ram[bus.mem_addr[7:2]] <= bus.mem_wr_data;
   end

   typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
   rsp_t rq[$];
   wr_t  wq[$];

   int last_acc = 0;
   int last_lat = 0;
   bit b2b_chk  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : mon
      rsp_t r;
      wr_t  w;
      if (bus.mem_wr_en === 1'b1) begin
         if (wq.size() == 0) chk("wr_unexpected", bus.mem_wr_en, 1'b0);
         else begin
            w = wq.pop_front();
            chk("wr_cycle", cyc, w.cyc);
            chk("wr_addr", bus.mem_addr, w.addr);
            chk("wr_data", bus.mem_wr_data, w.data);
         end
      end
      if (bus.rsp_valid === 1'b1) begin
         if (rq.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 1'b0);
         else begin
            r = rq.pop_front();
            chk("rsp_cycle", cyc, r.cyc);
            chk("rsp_err", bus.rsp_err, r.err);
            chk("rsp_rdata", bus.rsp_rdata, r.rdata);
         end
      end
   end

   // Drive one request, wait for acceptance, predict its outcome from the reference RAM.
   task automatic send(input bit we, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] wd, input bit track);
      int          guard, lat;
      logic        err;
      logic [31:0] w, rd, m;
      logic [7:0]  b;
      logic [15:0] h;
      rsp_t        r;
      wr_t         wr;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = sz;
      bus.req_unsigned = u;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
      guard = 0;
      while (bus.req_ready !== 1'b1 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      if (bus.req_ready !== 1'b1) begin
         chk("accept_timeout", bus.req_ready, 1'b1);
         return;
      end
      if (b2b_chk) chk("b2b_accept", cyc, last_acc + last_lat + 1);
      err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      w   = ref_mem[a[7:2]];
      rd  = 32'h0;
      m   = w;
      if (err) lat = 1;
      else if (!we) begin
         lat = 2;
         b = 8'(w >> (8 * a[1:0]));
         h = a[1] ? w[31:16] : w[15:0];
         if (sz == 2'b00)      rd = u ? {24'h0, b} : {{24{b[7]}}, b};
         else if (sz == 2'b01) rd = u ? {16'h0, h} : {{16{h[15]}}, h};
         else                  rd = w;
      end else if (sz == 2'b10) begin
         lat = 2;
         m   = wd;
      end else begin
         lat = 3;
         if (sz == 2'b01) begin
            if (a[1]) m[31:16] = wd[15:0];
            else      m[15:0]  = wd[15:0];
         end else begin
            case (a[1:0])
               2'd0: m[7:0]   = wd[7:0];
               2'd1: m[15:8]  = wd[7:0];
               2'd2: m[23:16] = wd[7:0];
               default: m[31:24] = wd[7:0];
            endcase
         end
      end
      if (track) begin
         r.rdata = rd; r.err = err; r.cyc = cyc + lat;
         rq.push_back(r);
         if (we && !err) begin
            wr.addr = {a[31:2], 2'b00}; wr.data = m; wr.cyc = cyc + lat - 1;
            wq.push_back(wr);
            ref_mem[a[7:2]] = m;
         end
      end
      last_acc = cyc;
      last_lat = lat;
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          guard;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
      bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);

      repeat (3) @(negedge clk);
      chk("rst_ready", bus.req_ready, 1'b1);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_err", bus.rsp_err, 1'b0);
      chk("rst_wr_en", bus.mem_wr_en, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_wr_data", bus.mem_wr_data, 32'h0);
      preload = 1'b0;
      rst_n   = 1'b1;
      @(negedge clk);

      // Reset while in RMW_RD: request dropped, no write, no response.
      send(1'b1, 2'b00, 1'b0, 32'h24, 32'hCC, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      #1 chk("midrst_ready", bus.req_ready, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_ready", bus.req_ready, 1'b1);
      chk("post_rst_rsp_valid", bus.rsp_valid, 1'b0);

      // Word store then load.
      send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1); idle(2);
      send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);         idle(2);
      // Byte store read-modify-write into 0x11223344.
      send(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AA, 1'b1); idle(2);
      // Signed/unsigned loads of 0x80FF7F01.
      send(1'b0, 2'b00, 1'b0, 32'h32, 32'h0, 1'b1); idle(1);
      send(1'b0, 2'b00, 1'b1, 32'h32, 32'h0, 1'b1); idle(1);
      send(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1'b1); idle(1);
      send(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 1'b1); idle(1);
      // Half store into the upper lane, then reload it.
      send(1'b1, 2'b01, 1'b0, 32'h2A, 32'h0000_5A6B, 1'b1); idle(1);
      send(1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 1'b1);         idle(1);
      // Error cases: misaligned half, misaligned word store, illegal size.
      send(1'b0, 2'b01, 1'b0, 32'h31, 32'h0, 1'b1);         idle(1);
      send(1'b1, 2'b10, 1'b0, 32'h42, 32'h1234_5678, 1'b1); idle(1);
      send(1'b0, 2'b11, 1'b0, 32'h50, 32'h0, 1'b1);         idle(1);

      // Back-to-back mixed requests with req_valid held high.
      for (int k = 0; k < 9; k++) begin
         a = 32'($urandom_range(0, 255));
         case (k % 3)
            0: begin
               sz = 2'($urandom_range(0, 1));
               if (sz == 2'b01) a[0] = 1'b0;
               send(1'b1, sz, 1'b0, a, $urandom, 1'b1);
            end
            1: begin
               sz = 2'($urandom_range(0, 2));
               if (sz == 2'b01) a[0] = 1'b0;
               if (sz == 2'b10) a[1:0] = 2'b00;
               send(1'b0, sz, 1'($urandom_range(0, 1)), a, 32'h0, 1'b1);
            end
            default: begin
               a[1:0] = 2'b00;
               send(1'b1, 2'b10, 1'b0, a, $urandom, 1'b1);
            end
         endcase
         b2b_chk = 1'b1;
      end
      b2b_chk = 1'b0;
      idle(1);

      guard = 0;
      while ((rq.size() != 0 || wq.size() != 0) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("rsp_drain", rq.size(), 32'h0);
      chk("wr_drain", wq.size(), 32'h0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 64; i++) chk($sformatf("ram[%0d]", i), ram[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
